// File: rtl/vanilla_pc_hist_sched_if.sv
// Event-in / histogram-update-out bundle for vanilla_pc_hist_sched.
// The scheduler takes the slave side; a requester/engine model takes master.
interface vanilla_pc_hist_sched_if #(
  parameter int num_req_p  = 4,
  parameter int pc_width_p = 32,
  parameter int op_width_p = 5
);
  logic [num_req_p-1:0]            ev_v_i;
  logic [num_req_p*pc_width_p-1:0] ev_pc_i;
  logic [num_req_p*op_width_p-1:0] ev_op_i;
  logic                            hist_v_o;
  logic [pc_width_p-1:0]           hist_pc_o;
  logic [op_width_p-1:0]           hist_op_o;
  logic [$clog2(num_req_p)-1:0]    hist_src_o;
  logic                            hist_ready_i;

  modport slave (
    input  ev_v_i, ev_pc_i, ev_op_i, hist_ready_i,
    output hist_v_o, hist_pc_o, hist_op_o, hist_src_o
  );

  modport master (
    output ev_v_i, ev_pc_i, ev_op_i, hist_ready_i,
    input  hist_v_o, hist_pc_o, hist_op_o, hist_src_o
  );
endinterface

// File: rtl/vanilla_pc_hist_sched.sv
// PC-histogram event scheduler: per-requester holding slots, round-robin grant, IDLE/RUN/DRAIN.
// Define VANILLA_PC_HIST_SCHED_DROP_COUNT_EN to build the saturating drop counter.
module vanilla_pc_hist_slot #(
  parameter int pc_width_p = 32,
  parameter int op_width_p = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  clr,
  input  logic [pc_width_p-1:0] wr_pc,
  input  logic [op_width_p-1:0] wr_op,
  output logic                  held_v,
  output logic [pc_width_p-1:0] held_pc,
  output logic [op_width_p-1:0] held_op
);
  // A write in the same cycle as the handshake refills the slot instead of emptying it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_v  <= 1'b0;
      held_pc <= '0;
      held_op <= '0;
    end else if (wr) begin
      held_v  <= 1'b1;
      held_pc <= wr_pc;
      held_op <= wr_op;
    end else if (clr) begin
      held_v  <= 1'b0;
    end
  end
endmodule

module vanilla_pc_hist_sched #(
  parameter int num_req_p        = 4,
  parameter int pc_width_p       = 32,
  parameter int op_width_p       = 5,
  parameter int drop_cnt_width_p = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        enable_i,
  vanilla_pc_hist_sched_if.slave      bus,
  output logic                        busy_o,
  output logic                        drain_done_o,
  output logic [drop_cnt_width_p-1:0] drop_count_o
);
  localparam int src_w = $clog2(num_req_p);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  state_e state, state_nxt;

  logic [num_req_p-1:0]                 slot_v, wr, clr;
  logic [num_req_p-1:0][pc_width_p-1:0] slot_pc;
  logic [num_req_p-1:0][op_width_p-1:0] slot_op;
  logic [src_w-1:0] rr_ptr, lock_idx, arb_idx, gnt, cand;
  logic             arb_found, locked, hist_v, hs;

  for (genvar i = 0; i < num_req_p; i++) begin : g_slot
    assign clr[i] = hs && (gnt == src_w'(i));
    assign wr[i]  = (state == RUN) && bus.ev_v_i[i] && (!slot_v[i] || clr[i]);

    vanilla_pc_hist_slot #(.pc_width_p(pc_width_p), .op_width_p(op_width_p)) u_slot (
      .clk     (clk_i),
      .rst     (reset_i),
      .wr      (wr[i]),
      .clr     (clr[i]),
      .wr_pc   (bus.ev_pc_i[i*pc_width_p +: pc_width_p]),
      .wr_op   (bus.ev_op_i[i*op_width_p +: op_width_p]),
      .held_v  (slot_v[i]),
      .held_pc (slot_pc[i]),
      .held_op (slot_op[i])
    );
  end

  // Round-robin search starting at rr_ptr (one past the last handshaked requester).
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < num_req_p; k++) begin
      cand = src_w'((int'(rr_ptr) + k) % num_req_p);
      if (!arb_found && slot_v[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // A stalled offer keeps its grant; slot contents cannot change while full and unfreed.
  assign gnt    = locked ? lock_idx : arb_idx;
  assign hist_v = (state != IDLE) && arb_found;
  assign hs     = hist_v && bus.hist_ready_i;

  assign bus.hist_v_o   = hist_v;
  assign bus.hist_pc_o  = hist_v ? slot_pc[gnt] : '0;
  assign bus.hist_op_o  = hist_v ? slot_op[gnt] : '0;
  assign bus.hist_src_o = hist_v ? gnt : '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      locked   <= 1'b0;
      lock_idx <= '0;
      rr_ptr   <= '0;
    end else begin
      locked   <= hist_v && !bus.hist_ready_i;
      lock_idx <= gnt;
      if (hs) rr_ptr <= (gnt == src_w'(num_req_p - 1)) ? '0 : gnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // enable_i is not looked at in DRAIN, so a re-enable waits for the drain to finish.
  always_comb begin
    state_nxt    = state;
    drain_done_o = 1'b0;
    case (state)
      IDLE:  if (enable_i) state_nxt = RUN;
      RUN:   if (!enable_i) state_nxt = DRAIN;
      DRAIN: if (!(|slot_v)) begin
        state_nxt    = IDLE;
        drain_done_o = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

`ifdef VANILLA_PC_HIST_SCHED_DROP_COUNT_EN
  // Headroom of 5 bits covers up to 16 simultaneous drops before the saturation compare.
  localparam int sum_w = drop_cnt_width_p + 5;
  logic [num_req_p-1:0]        drop;
  logic [sum_w-1:0]            drop_sum;
  logic [drop_cnt_width_p-1:0] drop_cnt;

  always_comb begin
    drop     = {num_req_p{state == RUN}} & bus.ev_v_i & slot_v & ~clr;
    drop_sum = sum_w'(drop_cnt);
    for (int i = 0; i < num_req_p; i++) drop_sum = drop_sum + sum_w'(drop[i]);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                                           drop_cnt <= '0;
    else if (drop_sum > sum_w'({drop_cnt_width_p{1'b1}})) drop_cnt <= '1;
    else                                                   drop_cnt <= drop_cnt_width_p'(drop_sum);
  end

  assign drop_count_o = drop_cnt;
`else
  assign drop_count_o = '0;
`endif
endmodule
